// File: rtl/morse_decoder.sv
// Purpose : decodes a hand-keyed Morse signal into ASCII characters (A-Z, 0-9, '?' for bad letters,
//           space after a word pause).
// Latency : a character is presented one clk_24 cycle after its letter/word gap has elapsed.
// Backpressure: one-entry output register; a new character arriving while the previous one is
//           still unaccepted is dropped and the sticky overflow flag is raised.
// Ports   : clk_24 (24 MHz clock), rst (synchronous, active-low), key (raw key level, HI = mark),
//           out_valid/out_data/out_ready (valid-ready character stream), overflow (sticky drop flag),
//           busy (decoder not idle).
module morse_decoder #(
   parameter int UNIT_CYCLES = 1_200_000
) (
   input  logic       clk_24,
   input  logic       rst,
   input  logic       key,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       overflow,
   output logic       busy
);

   localparam int CNT_W = $clog2(5 * UNIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(5 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_DASH = CNT_W'(2 * UNIT_CYCLES);

   typedef enum logic [1:0] {IDLE, MARK, GAP, WORD_WAIT} state_t;

   state_t           state, state_nxt;
   logic             key_m, key_s, key_q;
   logic             key_rise, key_fall;
   logic [CNT_W-1:0] cnt;
   logic [6:0]       code;
   logic [2:0]       len;
   logic             err;
   logic             sym_push, letter_clr;
   logic             emit;
   logic [7:0]       emit_dat;

   // Map a received symbol pattern to ASCII. Bit n of code is the n-th symbol received
   // (1 = dash), so the binary literals below read as the Morse pattern reversed.
   function automatic logic [7:0] lookup(input logic [2:0] l, input logic [6:0] c, input logic e);
      logic [7:0] ch;
      ch = 8'h3F;
      case ({l, c})
         {3'd1, 7'b0000000}: ch = 8'h45; // E .
         {3'd1, 7'b0000001}: ch = 8'h54; // T -
         {3'd2, 7'b0000000}: ch = 8'h49; // I ..
         {3'd2, 7'b0000010}: ch = 8'h41; // A .-
         {3'd2, 7'b0000001}: ch = 8'h4E; // N -.
         {3'd2, 7'b0000011}: ch = 8'h4D; // M --
         {3'd3, 7'b0000000}: ch = 8'h53; // S ...
         {3'd3, 7'b0000100}: ch = 8'h55; // U ..-
         {3'd3, 7'b0000010}: ch = 8'h52; // R .-.
         {3'd3, 7'b0000110}: ch = 8'h57; // W .--
         {3'd3, 7'b0000001}: ch = 8'h44; // D -..
         {3'd3, 7'b0000101}: ch = 8'h4B; // K -.-
         {3'd3, 7'b0000011}: ch = 8'h47; // G --.
         {3'd3, 7'b0000111}: ch = 8'h4F; // O ---
         {3'd4, 7'b0000000}: ch = 8'h48; // H ....
         {3'd4, 7'b0001000}: ch = 8'h56; // V ...-
         {3'd4, 7'b0000100}: ch = 8'h46; // F ..-.
         {3'd4, 7'b0000010}: ch = 8'h4C; // L .-..
         {3'd4, 7'b0000110}: ch = 8'h50; // P .--.
         {3'd4, 7'b0001110}: ch = 8'h4A; // J .---
         {3'd4, 7'b0000001}: ch = 8'h42; // B -...
         {3'd4, 7'b0001001}: ch = 8'h58; // X -..-
         {3'd4, 7'b0000101}: ch = 8'h43; // C -.-.
         {3'd4, 7'b0001101}: ch = 8'h59; // Y -.--
         {3'd4, 7'b0000011}: ch = 8'h5A; // Z --..
         {3'd4, 7'b0001011}: ch = 8'h51; // Q --.-
         {3'd5, 7'b0011110}: ch = 8'h31; // 1 .----
         {3'd5, 7'b0011100}: ch = 8'h32; // 2 ..---
         {3'd5, 7'b0011000}: ch = 8'h33; // 3 ...--
         {3'd5, 7'b0010000}: ch = 8'h34; // 4 ....-
         {3'd5, 7'b0000000}: ch = 8'h35; // 5 .....
         {3'd5, 7'b0000001}: ch = 8'h36; // 6 -....
         {3'd5, 7'b0000011}: ch = 8'h37; // 7 --...
         {3'd5, 7'b0000111}: ch = 8'h38; // 8 ---..
         {3'd5, 7'b0001111}: ch = 8'h39; // 9 ----.
         {3'd5, 7'b0011111}: ch = 8'h30; // 0 -----
         default:            ch = 8'h3F;
      endcase
      if (e) ch = 8'h3F;
      return ch;
   endfunction

   // Two-flop synchronizer (key_m, key_s); key_q is key_s delayed, used only for edge detection.
   always_ff @(posedge clk_24) begin
      if (!rst) begin
         key_m <= 1'b0;
         key_s <= 1'b0;
         key_q <= 1'b0;
      end else begin
         key_m <= key;
         key_s <= key_m;
         key_q <= key_s;
      end
   end

   assign key_rise = key_s & ~key_q;
   assign key_fall = ~key_s & key_q;

   // Duration of the current key level; saturating keeps over-long marks classified as dashes.
   always_ff @(posedge clk_24) begin
      if (!rst) begin
         cnt <= '0;
      end else if (key_rise || key_fall) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_24) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      sym_push   = 1'b0;
      letter_clr = 1'b0;
      emit       = 1'b0;
      emit_dat   = 8'h00;
      case (state)
         IDLE: begin
            if (key_rise) state_nxt = MARK;
         end
         MARK: begin
            if (key_fall) begin
               sym_push  = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (key_rise) begin
               state_nxt = MARK;
            end else if (cnt == CNT_DASH) begin
               emit       = 1'b1;
               emit_dat   = lookup(len, code, err);
               letter_clr = 1'b1;
               state_nxt  = WORD_WAIT;
            end
         end
         WORD_WAIT: begin
            if (key_rise) begin
               state_nxt = MARK;
            end else if (cnt == CNT_MAX) begin
               emit      = 1'b1;
               emit_dat  = 8'h20;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Symbol accumulator; only seven symbols fit, anything beyond marks the letter as bad.
   always_ff @(posedge clk_24) begin
      if (!rst || letter_clr) begin
         code <= '0;
         len  <= '0;
         err  <= 1'b0;
      end else if (sym_push) begin
         if (len != 3'd7) begin
            code[len] <= (cnt >= CNT_DASH);
            len       <= len + 3'd1;
         end else begin
            err <= 1'b1;
         end
      end
   end

   // Output holding register. An emit coinciding with an accept simply replaces the
   // character being consumed; only an emit against a stalled character is a drop.
   always_ff @(posedge clk_24) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         overflow  <= 1'b0;
      end else if (emit) begin
         if (out_valid && !out_ready) begin
            overflow <= 1'b1;
         end else begin
            out_valid <= 1'b1;
            out_data  <= emit_dat;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder with UNIT_CYCLES = 10: expected characters are queued when a letter is
// keyed and compared when the decoder hands a character over (out_valid & out_ready).
// Port summary mirrors the DUT; inputs change 1 time unit after the rising edge.
module tb_morse_decoder;

   localparam int UNIT = 10;

   logic       clk_24 = 1'b0;
   logic       rst = 1'b0;
   logic       key = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       overflow;
   logic       busy;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];

   morse_decoder #(.UNIT_CYCLES(UNIT)) dut (
      .clk_24    (clk_24),
      .rst       (rst),
      .key       (key),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk_24 = ~clk_24;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_24);
         #1;
      end
   endtask

   task automatic mark(input int n);
      key = 1'b1;
      tick(n);
      key = 1'b0;
   endtask

   task automatic send_letter(input string p);
      for (int i = 0; i < p.len(); i++) begin
         mark((p[i] == "-") ? 3 * UNIT : UNIT);
         if (i != p.len() - 1) tick(UNIT);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
   endtask

   // Scoreboard: every accepted character must match the oldest expected one.
   initial begin
      forever begin
         @(negedge clk_24);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check_eq("pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("char", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      string      pats[7];
      logic [7:0] chars[7];
      pats  = '{"...", "---", "...", "-.-", "-----", "..---", "--.-"};
      chars = '{8'h53, 8'h4F, 8'h53, 8'h4B, 8'h30, 8'h32, 8'h51};

      // Reset state
      out_ready = 1'b1;
      tick(3);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 8'h00);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_busy", busy, 0);
      rst = 1'b1;
      tick(5);

      // Single dot -> 'E' then word space
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h20);
      mark(UNIT);
      tick(6 * UNIT);
      check_eq("e_drained", exp_q.size(), 0);

      // dot-dash -> 'A', no space in between
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h20);
      send_letter(".-");
      tick(6 * UNIT);
      check_eq("a_drained", exp_q.size(), 0);

      // Eight dots -> '?'
      exp_q.push_back(8'h3F);
      exp_q.push_back(8'h20);
      send_letter("........");
      tick(6 * UNIT);

      // Word of several letters and digits with letter gaps of three units
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(chars[i]);
         send_letter(pats[i]);
         tick(3 * UNIT);
      end
      exp_q.push_back(8'h20);
      tick(4 * UNIT);
      check_eq("word_drained", exp_q.size(), 0);

      // Mark far beyond saturation still decodes as dash
      exp_q.push_back(8'h54);
      exp_q.push_back(8'h20);
      mark(7 * UNIT);
      tick(6 * UNIT);
      check_eq("long_drained", exp_q.size(), 0);

      // Stalled consumer: 'E' held, 'T' and the space are dropped
      out_ready = 1'b0;
      exp_q.push_back(8'h45);
      mark(UNIT);
      tick(3 * UNIT);
      mark(3 * UNIT);
      tick(6 * UNIT);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, 8'h45);
      check_eq("stall_overflow", overflow, 1);
      out_ready = 1'b1;
      tick(1);
      check_eq("stall_accept", exp_q.size(), 0);
      tick(1);
      check_eq("stall_valid_drop", out_valid, 0);
      check_eq("overflow_sticky", overflow, 1);
      do_reset();
      check_eq("overflow_cleared", overflow, 0);
      tick(3);

      // Accept in the very cycle the word space is emitted: no drop
      out_ready = 1'b0;
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h20);
      mark(UNIT);
      begin
         int w = 0;
         while (out_valid !== 1'b1 && w < 200) begin
            @(negedge clk_24);
            w++;
         end
      end
      check_eq("e_seen", out_valid, 1);
      // Space emit lands 29 cycles after the first cycle 'E' is valid
      repeat (29) @(posedge clk_24);
      #1;
      out_ready = 1'b1;
      @(posedge clk_24);
      #1;
      out_ready = 1'b0;
      check_eq("same_cycle_valid", out_valid, 1);
      check_eq("same_cycle_data", out_data, 8'h20);
      check_eq("same_cycle_overflow", overflow, 0);
      out_ready = 1'b1;
      tick(3);
      check_eq("same_cycle_drained", exp_q.size(), 0);
      tick(2 * UNIT);

      // Reset in the middle of the second mark of 'A': nothing comes out
      mark(UNIT);
      tick(UNIT);
      key = 1'b1;
      tick(UNIT);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      key = 1'b0;
      tick(8 * UNIT);
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_busy", busy, 0);

      // Key already HI at reset release starts a mark after the synchronizer delay
      key = 1'b1;
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(2);
      check_eq("held_busy_early", busy, 0);
      tick(1);
      check_eq("held_busy", busy, 1);
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h20);
      tick(UNIT);
      key = 1'b0;
      tick(7 * UNIT);

      check_eq("final_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 1_200_000, meaning clk_24 cycles per Morse unit (one dot, 50 ms at 24 MHz).
REQ-002 SHALL have port clk_24  input  1  system clock, 24 MHz.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port key  input  1  Morse key level, HI = mark, may be asynchronous.
REQ-005 SHALL have port out_valid  output  1  decoded character available.
REQ-006 SHALL have port out_data  output  8  decoded ASCII character.
REQ-007 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 SHALL have port overflow  output  1  sticky flag, character dropped.
REQ-009 SHALL have port busy  output  1  HI when FSM is not IDLE.

Function
REQ-010 SHALL pass key through a 2-flop synchronizer; key_s is the second flop; all timing is relative to key_s.
REQ-011 SHALL keep a duration counter cnt: cleared to 0 on any key_s edge, else +1 per cycle, saturating at 5*UNIT_CYCLES; width ceil(log2(5*UNIT_CYCLES+1)).
REQ-012 SHALL implement FSM states IDLE, MARK, GAP, WORD_WAIT.
REQ-013 IDLE: key_s rise -> MARK; otherwise stay; no output is generated.
REQ-014 MARK: key_s fall -> classify symbol and go to GAP; classification is dash if cnt >= 2*UNIT_CYCLES, else dot.
REQ-015 Symbol storage SHALL be code[6:0] and len[2:0]; symbol n (0-based reception order) goes to code[n], 1 = dash; len increments per symbol.
REQ-016 An 8th or later symbol SHALL NOT be stored and SHALL set an internal err bit for the current letter.
REQ-017 GAP: key_s rise before cnt reaches 2*UNIT_CYCLES -> MARK (same letter).
REQ-018 GAP: cnt == 2*UNIT_CYCLES -> letter end: emit character, clear code/len/err, go to WORD_WAIT.
REQ-019 WORD_WAIT: key_s rise -> MARK (new letter); cnt == 5*UNIT_CYCLES -> emit 8'h20 (space) and go to IDLE.
REQ-020 Lookup SHALL map (code, len) to uppercase A-Z (8'h41-8'h5A) and digits 0-9 (8'h30-8'h39) per ITU Morse; unmapped pattern or err=1 SHALL yield '?' (8'h3F).
REQ-021 Emit SHALL register out_data and assert out_valid on the clock edge following the emit condition (latency 1 cycle).
REQ-022 out_valid SHALL stay HI and out_data stable until a cycle with out_valid & out_ready; out_valid SHALL drop on the next edge.
REQ-023 Emit while out_valid HI and out_ready LO SHALL drop the new character, keep the old one, and set overflow.
REQ-024 Emit in the same cycle as an accept (out_valid & out_ready) SHALL load the new character with out_valid kept HI and no overflow.
REQ-025 overflow SHALL clear only on reset.
REQ-026 A mark longer than 5*UNIT_CYCLES SHALL still classify as dash (saturated count).

Reset
REQ-027 With rst LO at a clk_24 edge, the block SHALL go to IDLE with out_valid=0, out_data=8'h00, overflow=0, busy=0, cnt=0, code/len/err=0, and synchronizer flops=0.
REQ-028 Reset mid-letter SHALL discard pending symbols; no character SHALL be emitted for them after release.
REQ-029 After release, a key already HI SHALL register as a rise 2 cycles later and start MARK.

Verification (UNIT_CYCLES=10)
REQ-030 Key HI 10 cycles then LO -> out_valid HI with out_data 8'h45 ('E'); after 50 cycles low, 8'h20 follows (out_ready HI).
REQ-031 Key HI 10, LO 10, HI 30, LO -> single character 8'h41 ('A'), no space before it.
REQ-032 Eight 10-cycle dots separated by 10-cycle gaps -> 8'h3F ('?').
REQ-033 out_ready LO, letters 'E' then 'T' -> out_data stays 8'h45, overflow=1; raising out_ready gives one accept, then out_valid=0.
REQ-034 rst LO for 1 cycle during the 2nd mark of 'A', key then LO -> out_valid stays 0, busy=0.
REQ-035 out_ready pulsed HI in the exact cycle a new emit occurs -> new char presented next cycle, overflow stays 0.
